// File: rtl/function_sweep_ctrl.sv
// Sweep sequencer for a 4-input/1-output function block. It drives vectors 0..15 in order,
// waits SETTLE_CYCLES per vector, samples f, and compares the result with an expected truth table.
module function_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int SETTLE_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    output logic        fn_a,
    output logic        fn_b,
    output logic        fn_c,
    output logic        fn_d,
    input  logic        fn_f,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [15:0] truth_table,
    output logic        mismatch,
    output logic [3:0]  first_err_idx,
    output logic [4:0]  err_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    logic [1:0]          state;
    logic [3:0]          idx;
    logic [3:0]          vec;
    logic [SETTLE_W-1:0] settle;
    logic [15:0]         exp_q;

    // The drive vector is kept separate from idx so fn_* can return to 0 in DONE.
    assign fn_a = vec[3];
    assign fn_b = vec[2];
    assign fn_c = vec[1];
    assign fn_d = vec[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            idx           <= 4'd0;
            vec           <= 4'd0;
            settle        <= '0;
            exp_q         <= 16'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            valid         <= 1'b0;
            truth_table   <= 16'd0;
            mismatch      <= 1'b0;
            first_err_idx <= 4'd0;
            err_count     <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        exp_q         <= expected;
                        truth_table   <= 16'd0;
                        mismatch      <= 1'b0;
                        first_err_idx <= 4'd0;
                        err_count     <= 5'd0;
                        valid         <= 1'b0;
                        idx           <= 4'd0;
                        vec           <= 4'd0;
                        settle        <= SETTLE_LOAD;
                        busy          <= 1'b1;
                        state         <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Abort outranks the sample edge, so a last-vector abort never raises done.
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        vec   <= 4'd0;
                    end else if (settle != '0) begin
                        settle <= settle - 1'b1;
                    end else begin
                        truth_table[idx] <= fn_f;
                        if (fn_f != exp_q[idx]) begin
                            err_count <= err_count + 5'd1;
                            if (!mismatch) begin
                                mismatch      <= 1'b1;
                                first_err_idx <= idx;
                            end
                        end
                        if (idx != 4'd15) begin
                            idx    <= idx + 4'd1;
                            vec    <= idx + 4'd1;
                            settle <= SETTLE_LOAD;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            valid <= 1'b1;
                            vec   <= 4'd0;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    vec   <= 4'd0;
                end
            endcase
        end
    end

endmodule
